// File: rtl/payload_match_collector_if.sv
// Rule-ID record stream from the payload match collector to the alert logic.
// One record per set hit line (or a single "no hits" record), valid/ready handshake.
interface payload_match_collector_if #(
   parameter int ID_W  = 6,
   parameter int SEQ_W = 8
);
   logic             m_valid;
   logic             m_ready;
   logic [ID_W-1:0]  m_id;
   logic [SEQ_W-1:0] m_seq;
   logic             m_last;
   logic             m_none;

   modport master (
      output m_valid,
      input  m_ready,
      output m_id,
      output m_seq,
      output m_last,
      output m_none
   );

   modport slave (
      input  m_valid,
      output m_ready,
      input  m_id,
      input  m_seq,
      input  m_last,
      input  m_none
   );
endinterface

// File: rtl/payload_match_collector.sv
// Payload match collector.
// Snapshots the sticky engine hit lines one cycle after the last enabled payload
// byte, then serialises the set indices (lowest first) as rule-ID records.
// Packets that end while a previous packet is still being reported are dropped;
// they still consume a sequence number so the gap in m_seq marks the loss.
module payload_match_collector #(
   parameter int N_ENG  = 64,
   parameter int ID_W   = 6,
   parameter int SEQ_W  = 8,
   parameter int DROP_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sod,
   input  logic                   eod,
   input  logic [N_ENG-1:0]       hits,
   payload_match_collector_if.master rec,
   output logic                   busy,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [N_ENG-1:0] snap;
   logic [SEQ_W-1:0] seq;
   logic [SEQ_W-1:0] cur_seq;

   logic             eod_acc;
   logic             scan;
   logic             snap_zero;
   logic             snap_one;
   logic             rec_last;
   logic             handshake;
   logic [ID_W-1:0]  low_id;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [ID_W-1:0] lowest_set(input logic [N_ENG-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = N_ENG - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = ID_W'(i);
         end
      end
      return idx;
   endfunction

   // True when exactly one bit is set (v is a non-zero power of two).
   function automatic logic single_bit(input logic [N_ENG-1:0] v);
      return (v != '0) && ((v & (v - N_ENG'(1))) == '0);
   endfunction

   assign eod_acc   = eod & en;
   assign scan      = (state == SCAN);
   assign snap_zero = (snap == '0);
   assign snap_one  = single_bit(snap);
   assign rec_last  = snap_one | snap_zero;
   assign low_id    = lowest_set(snap);
   assign handshake = scan & rec.m_ready;

   // FSM state register; reset kills any in-flight record stream immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and stream outputs; record fields are forced to 0 outside SCAN.
   always_comb begin
      state_nxt   = state;
      rec.m_valid = 1'b0;
      rec.m_id    = '0;
      rec.m_seq   = '0;
      rec.m_last  = 1'b0;
      rec.m_none  = 1'b0;
      busy        = (state != IDLE);
      proto_err   = 1'b0;
      case (state)
         IDLE: begin
            if (eod_acc) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Engines register the last byte at the eod edge; capture next edge.
            // A sod here may already be clearing the hit lines.
            proto_err = sod;
            state_nxt = SCAN;
         end
         SCAN: begin
            rec.m_valid = 1'b1;
            rec.m_id    = low_id;
            rec.m_seq   = cur_seq;
            rec.m_last  = rec_last;
            rec.m_none  = snap_zero;
            if (rec.m_ready && rec_last) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sequence numbering: every accepted end-of-data consumes a number, dropped or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq     <= '0;
         cur_seq <= '0;
      end else if (eod_acc) begin
         seq <= seq + SEQ_W'(1);
         if (state == IDLE) begin
            cur_seq <= seq;
         end
      end
   end

   // Hit snapshot: load at the end of WAIT, retire the lowest bit per handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap <= '0;
      end else if (state == WAIT) begin
         snap <= hits;
      end else if (handshake) begin
         snap <= snap & (snap - N_ENG'(1));
      end
   end

   // Saturating drop counter for packets that end while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (eod_acc && (state != IDLE) && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule
